// File: rtl/bcd_conv8b_if.sv
// Bus bundle for bcd_conv8b: conversion request, upstream binary value and
// carry, plus the BCD result and status flags.
//   master : drives start, bin_in, cout_in; observes bcd_out, busy, done, ovf
//   slave  : the converter side
interface bcd_conv8b_if;
    logic        start;
    logic [7:0]  bin_in;
    logic        cout_in;
    logic [11:0] bcd_out;
    logic        busy;
    logic        done;
    logic        ovf;

    modport master (
        output start, bin_in, cout_in,
        input  bcd_out, busy, done, ovf
    );

    modport slave (
        input  start, bin_in, cout_in,
        output bcd_out, busy, done, ovf
    );
endinterface

// File: rtl/bcd_conv8b.sv
// 8-bit binary to 3-digit BCD converter using sequential double dabble.
// One shift per clock; 8 shifts per conversion. Also keeps a sticky
// overflow flag fed by the upstream counter/adder carry-out.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd_conv8b_if
//           start   - conversion request, sampled only in IDLE
//           bin_in  - binary value, captured when start is accepted
//           cout_in - upstream carry, sets ovf on any edge
//           bcd_out - {hundreds, tens, ones}, held until the next result
//           busy    - high whenever the FSM is not IDLE
//           done    - one-cycle pulse with a fresh bcd_out
//           ovf     - sticky carry flag, cleared by an accepted start
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one double-dabble step per cycle, 8 steps
// DONE  | result published; back to IDLE, or recapture when CONT_MODE=1
module bcd_conv8b #(
    parameter bit CONT_MODE = 1'b0
) (
    input logic         clk,
    input logic         rst_n,
    bcd_conv8b_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    logic [11:0] scratch;
    logic [7:0]  sreg;
    logic [2:0]  cnt;
    logic [11:0] bcd_q;
    logic        busy_q;
    logic        done_q;
    logic        ovf_q;

    logic [11:0] adj;
    logic [11:0] scratch_next;
    logic        accept;

    // Add 3 to any digit >= 5 so that the following left shift carries
    // correctly into the next decimal digit.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 3; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
        end
        scratch_next = {adj[10:0], sreg[7]};
    end

    assign accept = (state == IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            scratch <= '0;
            sreg    <= '0;
            cnt     <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sreg    <= bus.bin_in;
                        scratch <= '0;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_next;
                    sreg    <= {sreg[6:0], 1'b0};
                    cnt     <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        bcd_q  <= scratch_next;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (CONT_MODE) begin
                        sreg    <= bus.bin_in;
                        scratch <= '0;
                        cnt     <= '0;
                        state   <= SHIFT;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase

            // A carry on the same edge as an accepted start keeps ovf set.
            if (bus.cout_in)
                ovf_q <= 1'b1;
            else if (accept)
                ovf_q <= 1'b0;
        end
    end

    assign bus.bcd_out = bcd_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: doc/bcd_conv8b.md
BCD_CONV8B -- requirements
Module: bcd_conv8b

Interface
REQ-001 SHALL have parameter CONT_MODE, default 0. When 1, the block restarts conversion automatically after every result.
REQ-002 SHALL have port clk, input, 1 bit. Single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit. Asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit. Conversion request; sampled only in IDLE.
REQ-005 SHALL have port bin_in, input, 8 bits. Unsigned binary value from the upstream 8-bit counter/adder output.
REQ-006 SHALL have port cout_in, input, 1 bit. Carry-out from the upstream counter/adder.
REQ-007 SHALL have port bcd_out, output, 12 bits. [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-008 SHALL have port busy, output, 1 bit. High whenever state is not IDLE.
REQ-009 SHALL have port done, output, 1 bit. One-cycle pulse; bcd_out is valid and new while done is high.
REQ-010 SHALL have port ovf, output, 1 bit. Sticky flag recording an upstream carry.

Function
REQ-011 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-012 In IDLE, start=1 at edge E0 SHALL capture bin_in into the shift register, clear the 12-bit BCD scratch and the 3-bit shift count, and move to SHIFT.
REQ-013 In each SHIFT cycle, the block SHALL add 3 to every scratch nibble that is >=5, then shift {scratch, shift register} left by 1, then increment the count (double dabble).
REQ-014 After the 8th shift (edge E8), the block SHALL load scratch into bcd_out and move to DONE.
REQ-015 Latency: done SHALL be high in the cycle after E8 (9 cycles after start is sampled); busy SHALL be high for exactly 9 cycles, from after E0 until E9.
REQ-016 DONE SHALL last exactly 1 cycle and then go to IDLE (CONT_MODE=0), or recapture bin_in and go to SHIFT (CONT_MODE=1).
REQ-017 start SHALL be ignored in SHIFT and DONE; requests are not queued.
REQ-018 bin_in SHALL be sampled only at capture; later changes to bin_in SHALL NOT affect the conversion in flight.
REQ-019 bcd_out SHALL hold its last result between conversions and change only at the E8 load.
REQ-020 Each bcd_out nibble SHALL lie in 0..9; the hundreds digit SHALL lie in 0..2 (maximum output 0x255).
REQ-021 ovf SHALL be set on any edge where cout_in=1, in every state.
REQ-022 ovf SHALL be cleared on the edge where a start is accepted in IDLE.
REQ-023 If a set and a clear of ovf occur on the same edge, set SHALL win.
REQ-024 start held high continuously with CONT_MODE=0 SHALL give back-to-back conversions, one every 10 cycles (IDLE visited for 1 cycle between them).

Reset
REQ-025 rst_n=0 SHALL immediately force: state IDLE, bcd_out=0x000, busy=0, done=0, ovf=0, scratch, shift register and count all cleared.
REQ-026 Reset mid-conversion SHALL abort it with no done pulse and bcd_out=0x000.
REQ-027 After reset is released, the first accepted start SHALL convert normally.

Verification
REQ-028 bin_in=255, start pulse -> done exactly 9 cycles later with bcd_out=0x255; busy high for 9 cycles.
REQ-029 bin_in=0, then 99, then 200 in separate conversions -> bcd_out=0x000, 0x099, 0x200 respectively.
REQ-030 start re-pulsed during SHIFT with bin_in changed to 7 after capture of 128 -> single done with bcd_out=0x128, and no second conversion.
REQ-031 cout_in pulse during SHIFT -> ovf=1 and held; next accepted start with cout_in=0 -> ovf=0; start accepted with cout_in=1 on the same edge -> ovf=1.
REQ-032 rst_n asserted low at shift 4 of a conversion of 173 -> outputs are zero at once, no done pulse; a new start with 173 -> bcd_out=0x173.
REQ-033 CONT_MODE=1, bin_in=42 held -> done pulses every 9 cycles with bcd_out=0x042 and busy never low.
